// File: rtl/ahblite_busmatrix_arbiter_rr.sv
// Output-stage arbiter for one AHB-Lite bus-matrix slave port: round-robin grant among
// NUM_PORTS masters, held across bursts. Define AHB_ARB_FIXED_PRIO_EN for fixed priority.
module ahblite_busmatrix_arbiter_rr #(
  parameter int NUM_PORTS = 4,
  parameter int SEL_W     = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] REQ,
  input  logic                 HREADY_Outputstage,
  input  logic                 HSEL_Outputstage,
  input  logic [1:0]           HTRANS_Outputstage,
  input  logic [2:0]           HBURST_Outputstage,
  output logic [SEL_W-1:0]     PORT_SEL_ARBITER,
  output logic                 PORT_NOSEL_ARBITER
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam int         REQ_EXT_W    = 2 ** SEL_W;

  logic [SEL_W-1:0]     port_sel_q, port_sel_d;
  logic                 port_nosel_q, port_nosel_d;
  logic [3:0]           beat_cnt_q, beat_cnt_d;
  logic                 incr_active_q, incr_active_d;
  logic                 locked;
  logic                 req_any;
  logic [SEL_W-1:0]     pick_idx;
  logic [REQ_EXT_W-1:0] req_ext;

  // Requests zero-padded to the full select range so any select value indexes safely.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_PORTS-1:0] = REQ;
    req_any                = |REQ;
  end

  // Burst tracking follows only the granted port's address phase.
  always_comb begin
    beat_cnt_d    = beat_cnt_q;
    incr_active_d = incr_active_q;
    if (HREADY_Outputstage) begin
      if (port_nosel_q || !HSEL_Outputstage) begin
        incr_active_d = 1'b0;
      end else begin
        case (HTRANS_Outputstage)
          TRANS_NONSEQ: begin
            incr_active_d = (HBURST_Outputstage == 3'b001);
            case (HBURST_Outputstage)
              3'b010, 3'b011: beat_cnt_d = 4'd3;
              3'b100, 3'b101: beat_cnt_d = 4'd7;
              3'b110, 3'b111: beat_cnt_d = 4'd15;
              default:        beat_cnt_d = 4'd0;
            endcase
          end
          TRANS_SEQ: begin
            if (beat_cnt_q != 4'd0) begin
              beat_cnt_d = beat_cnt_q - 4'd1;
            end
          end
          TRANS_IDLE: begin
            beat_cnt_d    = 4'd0;
            incr_active_d = 1'b0;
          end
          TRANS_BUSY: begin
            beat_cnt_d = beat_cnt_q;
          end
          default: begin
            beat_cnt_d = beat_cnt_q;
          end
        endcase
      end
    end
  end

  // Lock uses next-state values so the final SEQ beat frees the same edge's arbitration.
  assign locked = (beat_cnt_d != 4'd0) | incr_active_d;

`ifdef AHB_ARB_FIXED_PRIO_EN

  always_comb begin
    pick_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_ext[SEL_W'(i)]) begin
        pick_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    port_sel_d   = port_sel_q;
    port_nosel_d = port_nosel_q;
    if (HREADY_Outputstage && !locked) begin
      if (req_any) begin
        port_sel_d   = pick_idx;
        port_nosel_d = 1'b0;
      end else if (HSEL_Outputstage) begin
        port_nosel_d = 1'b0;
      end else begin
        port_nosel_d = 1'b1;
      end
    end
  end

`else

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] cand_idx;
  logic             found;

  // Search starts one past the last winner so every requester is reached within NUM_PORTS grants.
  always_comb begin
    pick_idx = '0;
    cand_idx = '0;
    found    = 1'b0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand_idx = SEL_W'((int'(rr_ptr_q) + off) % NUM_PORTS);
      if (!found && req_ext[cand_idx]) begin
        found    = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  always_comb begin
    port_sel_d   = port_sel_q;
    port_nosel_d = port_nosel_q;
    rr_ptr_d     = rr_ptr_q;
    if (HREADY_Outputstage && !locked) begin
      if (req_any) begin
        port_sel_d   = pick_idx;
        port_nosel_d = 1'b0;
        rr_ptr_d     = pick_idx;
      end else if (HSEL_Outputstage) begin
        port_nosel_d = 1'b0;
      end else begin
        port_nosel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rr_ptr_q <= SEL_W'(NUM_PORTS - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      port_sel_q    <= '0;
      port_nosel_q  <= 1'b1;
      beat_cnt_q    <= 4'd0;
      incr_active_q <= 1'b0;
    end else begin
      port_sel_q    <= port_sel_d;
      port_nosel_q  <= port_nosel_d;
      beat_cnt_q    <= beat_cnt_d;
      incr_active_q <= incr_active_d;
    end
  end

  assign PORT_SEL_ARBITER   = port_sel_q;
  assign PORT_NOSEL_ARBITER = port_nosel_q;

endmodule

// File: doc/ahblite_busmatrix_arbiter_rr.md
Name: ahblite_busmatrix_arbiter_rr

Overview:
Parametrised output-stage arbiter for one AHB-Lite bus-matrix slave port. Selects one of NUM_PORTS input stages (masters) to drive the slave.
- Round-robin among requesters.
- Grant is held for the whole of a defined-length or undefined-length burst.
- All decisions are gated by the slave-side HREADY.
- Sits between the input stages and the output-stage mux of each slave port. It generalises the two-input fixed-select arbiter to N masters with burst awareness.

Parameters:
NUM_PORTS, 4, number of master-side input stages competing for this slave port (2..16)
SEL_W, 2, width of encoded port select; must satisfy 2^SEL_W >= NUM_PORTS

Ports:
HCLK  input  1  system clock
HRESETn  input  1  asynchronous active-low reset
REQ  input  NUM_PORTS  per-master request; bit i high = input stage i addresses this slave in its current address phase
HREADY_Outputstage  input  1  HREADY returned by the slave; arbitration point qualifier
HSEL_Outputstage  input  1  HSEL currently driven to the slave by the granted port
HTRANS_Outputstage  input  2  HTRANS currently driven by the granted port
HBURST_Outputstage  input  3  HBURST currently driven by the granted port
PORT_SEL_ARBITER  output  SEL_W  encoded index of granted port (registered)
PORT_NOSEL_ARBITER  output  1  high = no port granted; output stage drives IDLE (registered)

Behaviour:
- Single clock HCLK; asynchronous active-low reset HRESETn.
- Reset values: PORT_SEL_ARBITER=0, PORT_NOSEL_ARBITER=1, beat counter=0, incr_active=0, RR pointer=NUM_PORTS-1, so port 0 has first priority.
- All state updates only on a rising HCLK edge with HREADY_Outputstage=1. With HREADY=0, everything holds, including a grant to a port that has dropped REQ.
- Burst tracking applies to the granted port only and needs PORT_NOSEL=0 and HSEL_Outputstage=1.
  - NONSEQ with HBURST in {010,011}: beat counter loads 3.
  - NONSEQ with HBURST in {100,101}: loads 7.
  - NONSEQ with HBURST in {110,111}: loads 15.
  - NONSEQ with HBURST=001 (INCR): sets incr_active.
  - NONSEQ with HBURST=000 (SINGLE): no lock.
  - SEQ: counter decrements if nonzero. Counter is 4 bits and never wraps below 0.
  - IDLE (early termination, e.g. after ERROR): counter clears and incr_active clears.
  - BUSY: counter holds.
  - incr_active clears when the granted port presents NONSEQ with HBURST!=001, presents IDLE, or drops HSEL.
- locked = (counter!=0) | incr_active, evaluated on the next-state values. A NONSEQ that starts a burst locks from that edge onward.
- Arbitration on each HREADY=1 edge:
  - If locked: PORT_SEL and PORT_NOSEL hold.
  - Else if any REQ bit is set: grant the first set bit searching pointer+1, pointer+2, … modulo NUM_PORTS. PORT_SEL takes that index, PORT_NOSEL=0, pointer takes that index.
  - Else if HSEL_Outputstage=1: hold the current grant, NOSEL=0, so the outstanding data phase completes.
  - Else: PORT_NOSEL=1 and PORT_SEL holds its last value.
- Latency: a request seen on edge k is granted at edge k (output valid after edge k). This is one cycle from REQ assertion to a registered grant.
- Simultaneous events: the last beat of a burst (counter 1→0 on SEQ) unlocks for that same edge's arbitration.
- REQ bits at or above NUM_PORTS do not exist. PORT_SEL never exceeds NUM_PORTS-1.
- Reset mid-burst: immediate return to reset values. No lock survives reset.

Optional Feature:
AHB_ARB_FIXED_PRIO_EN
- Defined: round-robin is replaced by fixed priority; lowest-index requesting port wins at every unlocked arbitration point. The RR pointer is not implemented. Burst locking is unchanged.
- Undefined: round-robin as described above.

Test Plan:
1. Reset, REQ=0000, HSEL=0, HREADY=1 → PORT_NOSEL=1, PORT_SEL=0 held indefinitely.
2. REQ=1111 constantly, all SINGLE NONSEQ, HREADY=1 → PORT_SEL sequence 0,1,2,3,0,… one per cycle (with AHB_ARB_FIXED_PRIO_EN: always 0).
3. Port 2 granted, issues INCR4 (NONSEQ + 3 SEQ) while REQ=1011 → PORT_SEL stays 2 for 4 edges, then moves to 3.
4. Port 1 in INCR8 with HREADY=0 for 5 cycles mid-burst, other REQ high → PORT_SEL stays 1 through stalls and remaining beats, counter unaffected by stalled edges.
5. Port 0 in WRAP16, issues IDLE after 5 beats (ERROR case) with REQ=0100 → grant moves to 2 on that edge.
6. Port 3 in undefined INCR, 10 SEQ beats then NONSEQ SINGLE, REQ=0001 → held at 3 throughout INCR, moves to 0 on the SINGLE edge. HRESETn pulsed mid-burst → NOSEL=1, SEL=0 asynchronously.
